// File: rtl/ddr3_arb_pkg.sv
// Shared constants and state encoding for the DDR3 port arbiter.
package ddr3_arb_pkg;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned MASK_W  = DATA_W / 8;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StIdle    = 3'd1,
    StIssue   = 3'd2,
    StResp    = 3'd3,
    StRelease = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after i_last (wrapping) wins.
module rr_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand [NUM_REQ];
  logic             w_found;

  // Candidate k is the requester at distance k+1 from the last winner.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = IDX_W'((32'(i_last) + k + 1) % NUM_REQ);
    end
  end

  // Scan candidates in priority order and keep the first asserted one.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (i_en && !w_found && i_req[w_cand[k]]) begin
        w_found             = 1'b1;
        o_grant[w_cand[k]]  = 1'b1;
        o_idx               = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 substitute memory port between NUM_REQ requesters, one task at a time.
module ddr3_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ddr3_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W  = ddr3_arb_pkg::DATA_W,
  parameter int unsigned MASK_W  = ddr3_arb_pkg::MASK_W,
  parameter int unsigned TIMEOUT = ddr3_arb_pkg::TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*MASK_W-1:0] i_req_mask,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_resp_valid,
  output logic                      o_resp_err,
  output logic [DATA_W-1:0]         o_resp_rdata,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [MASK_W-1:0]         o_mem_mask,
  output logic [DATA_W-1:0]         o_mem_din,
  output logic                      o_mem_we,
  input  logic [DATA_W-1:0]         i_mem_dout,
  input  logic                      i_mem_rdy,
  input  logic                      i_mem_w_rdy,
  input  logic                      i_mem_initDone
);
  import ddr3_arb_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_last;
  logic [NUM_REQ-1:0] r_owner_oh;
  logic               r_task_we;
  logic [CNT_W-1:0]   r_wdog;
  logic               r_rel_seen;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic               r_resp_err;
  logic [DATA_W-1:0]  r_resp_rdata;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [MASK_W-1:0]  r_mem_mask;
  logic [DATA_W-1:0]  r_mem_din;
  logic               r_mem_we;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_done;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [MASK_W-1:0]  w_sel_mask;
  logic [DATA_W-1:0]  w_sel_wdata;

  assign w_arb_en = (r_state == StIdle);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  // Only the flag matching the task direction may complete it.
  assign w_done = r_task_we ? i_mem_w_rdy : i_mem_rdy;

  // AND-OR mux of the granted requester's payload.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_mask  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = w_sel_we | i_req_we[i];
        w_sel_addr  = w_sel_addr | i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_mask  = w_sel_mask | i_req_mask[i*MASK_W +: MASK_W];
        w_sel_wdata = w_sel_wdata | i_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Task sequencer; memory-side and response outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StInit;
      r_last       <= IDX_W'(NUM_REQ - 1);
      r_owner_oh   <= '0;
      r_task_we    <= 1'b0;
      r_wdog       <= '0;
      r_rel_seen   <= 1'b0;
      r_resp_valid <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_mask   <= '0;
      r_mem_din    <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        StInit: begin
          if (i_mem_initDone) r_state <= StIdle;
        end
        StIdle: begin
          if (|w_grant) begin
            r_last     <= w_grant_idx;
            r_owner_oh <= w_grant;
            r_task_we  <= w_sel_we;
            r_mem_addr <= w_sel_addr;
            r_mem_mask <= w_sel_mask;
            r_mem_din  <= w_sel_wdata;
            r_mem_we   <= w_sel_we;
            r_wdog     <= '0;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_done || (r_wdog == CNT_W'(TIMEOUT))) begin
            r_resp_valid <= r_owner_oh;
            r_resp_err   <= !w_done;
            r_mem_we     <= 1'b0;
            r_state      <= StResp;
            if (w_done && !r_task_we) r_resp_rdata <= i_mem_dout;
          end
        end
        StResp: begin
          // Flip bit 0 so the memory sees a new address and drops any stale ready.
          r_mem_addr <= r_mem_addr ^ ADDR_W'(1);
          r_mem_mask <= '0;
          r_rel_seen <= 1'b0;
          r_state    <= StRelease;
        end
        StRelease: begin
          r_rel_seen <= 1'b1;
          if (r_rel_seen && !i_mem_rdy && !i_mem_w_rdy) r_state <= StIdle;
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign o_req_ready  = w_grant;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_mask   = r_mem_mask;
  assign o_mem_din    = r_mem_din;
  assign o_mem_we     = r_mem_we;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter with a latency-modelled memory and a byte-array reference.
module tb_ddr3_port_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 512;
  localparam int unsigned MW  = 64;
  localparam int unsigned TO  = 255;
  localparam int unsigned LAT = 16;

  typedef struct {
    int          id;
    logic        we;
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] wdata;
    logic        err;
    int          t;
  } task_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          tb_valid [N];
  logic          tb_we    [N];
  logic [AW-1:0] tb_addr  [N];
  logic [MW-1:0] tb_mask  [N];
  logic [DW-1:0] tb_wdata [N];

  logic [N-1:0]    req_valid, req_we, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*MW-1:0] req_mask;
  logic [N*DW-1:0] req_wdata;
  logic            resp_err, mem_we, mem_rdy, mem_w_rdy, mem_init_done, mem_stuck;
  logic [DW-1:0]   resp_rdata, mem_din, mem_dout;
  logic [AW-1:0]   mem_addr;
  logic [MW-1:0]   mem_mask;

  always_comb begin
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_mask  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = tb_valid[i];
      req_we[i]                = tb_we[i];
      req_addr[i*AW +: AW]     = tb_addr[i];
      req_mask[i*MW +: MW]     = tb_mask[i];
      req_wdata[i*DW +: DW]    = tb_wdata[i];
    end
  end

  ddr3_port_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MASK_W  (MW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_mask     (req_mask),
    .i_req_wdata    (req_wdata),
    .o_req_ready    (req_ready),
    .o_resp_valid   (resp_valid),
    .o_resp_err     (resp_err),
    .o_resp_rdata   (resp_rdata),
    .o_mem_addr     (mem_addr),
    .o_mem_mask     (mem_mask),
    .o_mem_din      (mem_din),
    .o_mem_we       (mem_we),
    .i_mem_dout     (mem_dout),
    .i_mem_rdy      (mem_rdy),
    .i_mem_w_rdy    (mem_w_rdy),
    .i_mem_initDone (mem_init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory substitute ----------------
  // Ready rises LAT cycles after address/we settle and stays while they stay put.
  logic [7:0]    sram [2**AW];
  logic [AW-1:0] m_last_addr;
  logic          m_last_we;
  int            m_cnt;

  always_comb begin
    mem_dout = '0;
    for (int unsigned k = 0; k < MW; k++) mem_dout[8*k +: 8] = sram[AW'(32'(mem_addr) + k)];
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) sram[i] = i[7:0];
    m_cnt = 0; mem_rdy = 1'b0; mem_w_rdy = 1'b0; m_last_addr = '0; m_last_we = 1'b0;
    forever begin
      @(posedge clk);
      if (mem_addr != m_last_addr || mem_we != m_last_we) begin
        m_cnt     <= 0;
        mem_rdy   <= 1'b0;
        mem_w_rdy <= 1'b0;
      end else begin
        if (m_cnt < LAT) m_cnt <= m_cnt + 1;
        mem_rdy   <= !mem_stuck && !mem_we && (m_cnt + 1 >= LAT);
        mem_w_rdy <= !mem_stuck && mem_we && (m_cnt + 1 >= LAT);
        if (!mem_stuck && mem_we && (m_cnt + 1 == LAT)) begin
          for (int unsigned k = 0; k < MW; k++)
            if (mem_mask[k]) sram[AW'(32'(mem_addr) + k)] <= mem_din[8*k +: 8];
        end
      end
      m_last_addr <= mem_addr;
      m_last_we   <= mem_we;
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [7:0]    ref_mem [2**AW];
  task_t         sb [$];
  int            grant_log [$];
  int            model_last;
  logic          busy;
  logic          rel_chk;
  int            rel_at;
  logic [AW-1:0] rel_addr;
  logic [DW-1:0] last_rdata;
  logic          last_err;
  int            last_lat;

  initial begin
    int            w;
    int            j;
    task_t         e;
    logic [N-1:0]  exp_g;
    logic [DW-1:0] exp_line;
    logic [2:0]    we_ok;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = i[7:0];
    model_last = N - 1; busy = 1'b0; rel_chk = 1'b0; rel_at = 0; rel_addr = '0;
    last_rdata = '0; last_err = 1'b0; last_lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        model_last = N - 1;
        busy       = 1'b0;
        rel_chk    = 1'b0;
      end else begin
        if (rel_chk && cyc == rel_at) begin
          check("release_addr", DW'(mem_addr), DW'(rel_addr));
          check("release_we_mask", DW'({mem_we, mem_mask}), '0);
          rel_chk = 1'b0;
        end
        if (req_ready != '0) begin
          w = -1;
          for (int k = 1; k <= N; k++) begin
            j = (model_last + k) % N;
            if (w < 0 && tb_valid[j]) w = j;
          end
          exp_g = '0;
          if (w >= 0) exp_g[w] = 1'b1;
          check("grant", DW'(req_ready), DW'(exp_g));
          check("grant_while_busy", DW'(busy), '0);
          if (w >= 0) begin
            e.id = w; e.we = tb_we[w]; e.addr = tb_addr[w]; e.mask = tb_mask[w];
            e.wdata = tb_wdata[w]; e.err = mem_stuck; e.t = cyc;
            sb.push_back(e);
            grant_log.push_back(w);
            model_last = w;
            busy = 1'b1;
          end
        end
        if (mem_we) begin
          we_ok = {busy, 1'b0, 1'b0};
          if (sb.size() > 0) begin
            we_ok[1] = sb[0].we;
            we_ok[0] = (mem_addr == sb[0].addr);
          end
          check("mem_we_only_in_write_issue", DW'(we_ok), DW'(3'b111));
        end
        if (resp_valid != '0) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", DW'(resp_valid), '0);
          end else begin
            e = sb.pop_front();
            exp_g = '0;
            exp_g[e.id] = 1'b1;
            check("resp_onehot", DW'(resp_valid), DW'(exp_g));
            check("resp_err", DW'(resp_err), DW'(e.err));
            if (e.err) check("timeout_latency", DW'(cyc - e.t), DW'(TO + 2));
            else if (!e.we) begin
              for (int unsigned k = 0; k < MW; k++)
                exp_line[8*k +: 8] = ref_mem[AW'(32'(e.addr) + k)];
              check("resp_rdata", resp_rdata, exp_line);
            end else begin
              for (int unsigned k = 0; k < MW; k++)
                if (e.mask[k]) ref_mem[AW'(32'(e.addr) + k)] = e.wdata[8*k +: 8];
            end
            busy       = 1'b0;
            rel_chk    = 1'b1;
            rel_at     = cyc + 1;
            rel_addr   = e.addr ^ AW'(1);
            last_rdata = resp_rdata;
            last_err   = resp_err;
            last_lat   = cyc - e.t;
          end
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic do_req(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [MW-1:0] mask, input logic [DW-1:0] wd);
    int   n;
    logic got;
    @(posedge clk); #1;
    tb_we[id] = we; tb_addr[id] = addr; tb_mask[id] = mask; tb_wdata[id] = wd;
    tb_valid[id] = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 2000) begin @(negedge clk); n++; got = req_ready[id]; end
    check($sformatf("req%0d_ready", id), DW'(got), DW'(1));
    @(posedge clk); #1 tb_valid[id] = 1'b0;
    if (got) begin
      n = 0; got = 1'b0;
      while (!got && n < 600) begin @(negedge clk); n++; got = resp_valid[id]; end
      check($sformatf("req%0d_resp", id), DW'(got), DW'(1));
    end
  endtask

  task automatic run_random(input int id, input int cnt);
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    for (int j = 0; j < cnt; j++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = AW'($urandom);
      if (j == 0) a = AW'(18'h3FFE0 + id);
      m = (j % 3 == 0) ? '1 : {$urandom, $urandom};
      for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
      do_req(id, 1'($urandom_range(0, 1)), a, m, d);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, DW'(req_ready), '0);
    check({tag, "_resp_valid"}, DW'(resp_valid), '0);
    check({tag, "_resp_err"}, DW'(resp_err), '0);
    check({tag, "_resp_rdata"}, resp_rdata, '0);
    check({tag, "_mem_addr_mask_we"}, DW'({mem_addr, mem_mask, mem_we}), '0);
    check({tag, "_mem_din"}, mem_din, '0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] exp_d;
    int            exp_order [5];
    int            n;
    for (int i = 0; i < N; i++) begin
      tb_valid[i] = 1'b0; tb_we[i] = 1'b0; tb_addr[i] = '0; tb_mask[i] = '0; tb_wdata[i] = '0;
    end
    mem_init_done = 1'b0;
    mem_stuck     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Read before memory init: nothing may be accepted until initDone.
    fork
      do_req(0, 1'b0, 18'h00040, '0, '0);
      begin
        repeat (5) begin @(negedge clk); check("ready_before_init", DW'(req_ready), '0); end
        @(posedge clk); #1 mem_init_done = 1'b1;
      end
    join
    for (int k = 0; k < 64; k++) exp_d[8*k +: 8] = 8'(64 + k);
    check("p1_rdata", last_rdata, exp_d);
    check("p1_err", DW'(last_err), '0);

    // Masked write then read-back.
    do_req(1, 1'b1, 18'h00100, 64'h00000000000000FF, {64{8'hA5}});
    do_req(1, 1'b0, 18'h00100, '0, '0);
    for (int k = 0; k < 64; k++) exp_d[8*k +: 8] = (k < 8) ? 8'hA5 : 8'(k);
    check("p2_rdata", last_rdata, exp_d);

    // Four concurrent readers after a fresh pointer.
    pulse_reset();
    grant_log.delete();
    fork
      begin do_req(0, 1'b0, 18'h01000, '0, '0); do_req(0, 1'b0, 18'h01400, '0, '0); end
      do_req(1, 1'b0, 18'h01100, '0, '0);
      do_req(2, 1'b0, 18'h01200, '0, '0);
      do_req(3, 1'b0, 18'h01300, '0, '0);
    join
    exp_order = '{0, 1, 2, 3, 0};
    check("p3_grant_count", DW'(grant_log.size()), DW'(5));
    n = grant_log.size();
    for (int k = 0; k < 5; k++)
      if (k < n) check($sformatf("p3_grant_%0d", k), DW'(grant_log[k]), DW'(exp_order[k]));

    // Same address back-to-back must not complete on the stale ready.
    do_req(2, 1'b0, 18'h00200, '0, '0);
    do_req(2, 1'b0, 18'h00200, '0, '0);
    check("p4_b2b_latency_ge17", DW'(last_lat >= 17), DW'(1));

    // Hung memory: timeout abort, then normal service resumes.
    mem_stuck = 1'b1;
    do_req(3, 1'b0, 18'h00300, '0, '0);
    check("p5_err", DW'(last_err), DW'(1));
    mem_stuck = 1'b0;
    do_req(0, 1'b0, 18'h00340, '0, '0);
    check("p5_recover_err", DW'(last_err), '0);

    // Reset in ISSUE cycle 5.
    @(posedge clk); #1;
    tb_we[0] = 1'b0; tb_addr[0] = 18'h003C0; tb_mask[0] = '0; tb_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 2000) begin @(negedge clk); n++; end
    check("p6_ready", DW'(req_ready[0]), DW'(1));
    @(posedge clk); #1 tb_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1 rst = 1'b0;
    grant_log.delete();
    fork
      do_req(1, 1'b0, 18'h00500, '0, '0);
      do_req(0, 1'b0, 18'h00540, '0, '0);
    join
    check("p6_grant_count", DW'(grant_log.size()), DW'(2));
    if (grant_log.size() > 0) check("p6_first_grant", DW'(grant_log[0]), '0);

    // Random mixed traffic from all requesters.
    fork
      run_random(0, 6);
      run_random(1, 6);
      run_random(2, 6);
      run_random(3, 6);
    join
    repeat (5) @(posedge clk);
    check("sb_drained", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
